// File: rtl/thor2021_pkg.sv
// Shared branch-unit types: opcode encoding, instruction format, value type
// and opcode classification helpers.
package thor2021_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned VALUE_W  = 128;

    // J-class occupies 0x00-0x0D; each DJ op is its J counterpart plus 0x10.
    typedef enum logic [OPCODE_W-1:0] {
        JEQ   = 6'h00,
        JNE   = 6'h01,
        JLT   = 6'h02,
        JGE   = 6'h03,
        JLE   = 6'h04,
        JGT   = 6'h05,
        JLTU  = 6'h06,
        JGEU  = 6'h07,
        JLEU  = 6'h08,
        JGTU  = 6'h09,
        JBC   = 6'h0A,
        JBS   = 6'h0B,
        JEQZ  = 6'h0C,
        JNEZ  = 6'h0D,
        DJEQ  = 6'h10,
        DJNE  = 6'h11,
        DJLT  = 6'h12,
        DJGE  = 6'h13,
        DJLE  = 6'h14,
        DJGT  = 6'h15,
        DJLTU = 6'h16,
        DJGEU = 6'h17,
        DJLEU = 6'h18,
        DJGTU = 6'h19,
        DJBC  = 6'h1A,
        DJBS  = 6'h1B,
        DJEQZ = 6'h1C,
        DJNEZ = 6'h1D,
        NOP   = 6'h3F
    } opcode_e;

    typedef struct packed {
        opcode_e opcode;
    } br_fmt_t;

    typedef struct packed {
        br_fmt_t br;
    } instruction_t;

    typedef logic [VALUE_W-1:0] value_t;

    // True for the decrement-and-branch family.
    function automatic logic is_dj_op(input opcode_e op);
        case (op)
            DJEQ, DJNE, DJLT, DJGE, DJLE, DJGT,
            DJLTU, DJGEU, DJLEU, DJGTU,
            DJBC, DJBS, DJEQZ, DJNEZ: is_dj_op = 1'b1;
            default:                  is_dj_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/thor2021_branch_cmp.sv
// Combinational branch condition evaluation; DJ ops share the J compare.
module thor2021_branch_cmp
    import thor2021_pkg::*;
#(
    parameter int unsigned WID = 64
)(
    input  opcode_e        opcode,
    input  logic [WID-1:0] a,
    input  logic [WID-1:0] b,
    output logic           takb_c
);

    localparam int unsigned BIT_IDX_W = $clog2(WID);

    logic [BIT_IDX_W-1:0] bit_idx;
    logic                 eq;
    logic                 lt_s;
    logic                 lt_u;
    logic                 zero;
    logic                 bit_set;

    assign bit_idx = b[BIT_IDX_W-1:0];
    assign eq      = (a == b);
    assign lt_s    = ($signed(a) < $signed(b));
    assign lt_u    = (a < b);
    assign zero    = (a == '0);
    assign bit_set = a[bit_idx];

    // Select the condition for the opcode; anything else never branches.
    always_comb begin
        takb_c = 1'b0;
        case (opcode)
            JEQ,  DJEQ:  takb_c = eq;
            JNE,  DJNE:  takb_c = !eq;
            JLT,  DJLT:  takb_c = lt_s;
            JGE,  DJGE:  takb_c = !lt_s;
            JLE,  DJLE:  takb_c = lt_s || eq;
            JGT,  DJGT:  takb_c = !(lt_s || eq);
            JLTU, DJLTU: takb_c = lt_u;
            JGEU, DJGEU: takb_c = !lt_u;
            JLEU, DJLEU: takb_c = lt_u || eq;
            JGTU, DJGTU: takb_c = !(lt_u || eq);
            JBC,  DJBC:  takb_c = !bit_set;
            JBS,  DJBS:  takb_c = bit_set;
            JEQZ, DJEQZ: takb_c = zero;
            JNEZ, DJNEZ: takb_c = !zero;
            default:     takb_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/thor2021_branch_eval_pipe.sv
// Two-stage branch evaluator: S1 latches operands (pre-decremented for DJ
// ops), S2 holds the compare result and drives the result handshake.
module thor2021_branch_eval_pipe
    import thor2021_pkg::*;
#(
    parameter int unsigned WID  = 64,
    parameter int unsigned TAGW = 6
)(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  instruction_t     inst_i,
    input  logic [WID-1:0]   a_i,
    input  logic [WID-1:0]   b_i,
    input  logic             pred_i,
    input  logic [TAGW-1:0]  tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             takb_o,
    output logic             mispred_o,
    output logic             dec_wr_o,
    output logic [WID-1:0]   dec_val_o,
    output logic [TAGW-1:0]  tag_o
);

    logic            s1_valid;
    opcode_e         s1_op;
    logic [WID-1:0]  s1_a;
    logic [WID-1:0]  s1_b;
    logic            s1_pred;
    logic            s1_dj;
    logic [TAGW-1:0] s1_tag;

    logic            s1_adv;
    logic            s1_load;
    logic            accept;
    logic            in_dj;
    logic [WID-1:0]  in_opnd;
    logic            cmp_takb;

    assign s1_adv     = !out_valid_o || out_ready_i;
    assign s1_load    = !s1_valid || s1_adv;
    assign in_ready_o = rst_ni && !flush_i && s1_load;
    assign accept     = in_valid_i && in_ready_o;
    assign in_dj      = is_dj_op(inst_i.br.opcode);
    assign in_opnd    = in_dj ? (a_i - WID'(1)) : a_i;

    // S1: capture the operation; DJ ops store the decremented operand.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_op    <= NOP;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_pred  <= 1'b0;
            s1_dj    <= 1'b0;
            s1_tag   <= '0;
        end else begin
            if (flush_i) begin
                s1_valid <= 1'b0;
            end else if (s1_load) begin
                s1_valid <= in_valid_i;
            end
            if (accept) begin
                s1_op   <= inst_i.br.opcode;
                s1_a    <= in_opnd;
                s1_b    <= b_i;
                s1_pred <= pred_i;
                s1_dj   <= in_dj;
                s1_tag  <= tag_i;
            end
        end
    end

    thor2021_branch_cmp #(
        .WID (WID)
    ) u_cmp (
        .opcode (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .takb_c (cmp_takb)
    );

    // S2: register the result; fields only change when S1 moves forward.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            takb_o      <= 1'b0;
            mispred_o   <= 1'b0;
            dec_wr_o    <= 1'b0;
            dec_val_o   <= '0;
            tag_o       <= '0;
        end else begin
            if (flush_i) begin
                out_valid_o <= 1'b0;
            end else if (s1_adv) begin
                out_valid_o <= s1_valid;
            end
            if (s1_adv && s1_valid && !flush_i) begin
                takb_o    <= cmp_takb;
                mispred_o <= cmp_takb ^ s1_pred;
                dec_wr_o  <= s1_dj;
                dec_val_o <= s1_dj ? s1_a : '0;
                tag_o     <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_thor2021_branch_eval_pipe.sv
// Self-checking bench: 64-bit pipe against a queue-based reference model,
// plus a 32-bit instance for width-specific wrap and reset behaviour.
module tb_thor2021_branch_eval_pipe;
    import thor2021_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ni;

    logic         in_valid, in_ready, pred, flush, out_valid, out_ready;
    logic         takb, mispred, dec_wr;
    instruction_t inst;
    logic [63:0]  a, b, dec_val;
    logic [5:0]   tag, tag_o;

    logic         in_valid32, in_ready32, pred32, flush32, out_valid32, out_ready32;
    logic         takb32, mispred32, dec_wr32;
    instruction_t inst32;
    logic [31:0]  a32, b32, dec_val32;
    logic [5:0]   tag32, tag_o32;

    thor2021_branch_eval_pipe #(.WID(64), .TAGW(6)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .inst_i(inst), .a_i(a), .b_i(b), .pred_i(pred), .tag_i(tag), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .takb_o(takb),
        .mispred_o(mispred), .dec_wr_o(dec_wr), .dec_val_o(dec_val), .tag_o(tag_o)
    );

    thor2021_branch_eval_pipe #(.WID(32), .TAGW(6)) dut32 (
        .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid32), .in_ready_o(in_ready32),
        .inst_i(inst32), .a_i(a32), .b_i(b32), .pred_i(pred32), .tag_i(tag32), .flush_i(flush32),
        .out_valid_o(out_valid32), .out_ready_i(out_ready32), .takb_o(takb32),
        .mispred_o(mispred32), .dec_wr_o(dec_wr32), .dec_val_o(dec_val32), .tag_o(tag_o32)
    );

    typedef struct packed {
        logic        takb;
        logic        mis;
        logic        dwr;
        logic [63:0] dval;
        logic [5:0]  tag;
    } res_t;

    typedef struct {
        res_t r;
        int   cyc;
    } item_t;

    item_t      q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         fired = 0;
    logic       last_acc = 1'b0;
    logic [5:0] tag_ctr = 6'd0;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference: evaluate the branch rule directly on 64-bit integers.
    function automatic res_t model(input opcode_e op, input logic [63:0] av, input logic [63:0] bv,
                                   input logic p, input logic [5:0] tg);
        logic        dj, t;
        logic [63:0] x;
        longint      sx, sy;
        int          idx;
        dj  = op inside {DJEQ, DJNE, DJLT, DJGE, DJLE, DJGT, DJLTU, DJGEU, DJLEU, DJGTU,
                         DJBC, DJBS, DJEQZ, DJNEZ};
        x   = dj ? av - 64'd1 : av;
        sx  = longint'(x);
        sy  = longint'(bv);
        idx = int'(bv[5:0]);
        case (op)
            JEQ,  DJEQ:  t = (x == bv);
            JNE,  DJNE:  t = (x != bv);
            JLT,  DJLT:  t = (sx < sy);
            JGE,  DJGE:  t = (sx >= sy);
            JLE,  DJLE:  t = (sx <= sy);
            JGT,  DJGT:  t = (sx > sy);
            JLTU, DJLTU: t = (x < bv);
            JGEU, DJGEU: t = (x >= bv);
            JLEU, DJLEU: t = (x <= bv);
            JGTU, DJGTU: t = (x > bv);
            JBC,  DJBC:  t = !x[idx];
            JBS,  DJBS:  t = x[idx];
            JEQZ, DJEQZ: t = (x == 64'd0);
            JNEZ, DJNEZ: t = (x != 64'd0);
            default:     t = 1'b0;
        endcase
        return '{t, t ^ p, dj, dj ? x : 64'd0, tg};
    endfunction

    function automatic logic [63:0] rval();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'($urandom_range(0, 3));
            2:       return '1;
            3:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic opcode_e rop();
        int r;
        r = $urandom_range(0, 33);
        if (r >= 32) r = 63;
        return opcode_e'(6'(r));
    endfunction

    task automatic set_op(input opcode_e op, input logic [63:0] av, input logic [63:0] bv, input logic p);
        inst.br.opcode = op;
        a    = av;
        b    = bv;
        pred = p;
        tag  = tag_ctr;
        tag_ctr++;
    endtask

    // One clock: check handshake/result against the model at the falling edge.
    task automatic tick();
        logic exp_rdy;
        logic exp_ov;
        res_t got;
        @(negedge clk);
        exp_rdy = rst_ni && !flush && (q.size() < 2 || out_ready);
        check("in_ready", 128'(in_ready), 128'(exp_rdy));
        exp_ov = 1'b0;
        if (rst_ni && q.size() > 0) exp_ov = (cyc >= q[0].cyc + 2);
        check("out_valid", 128'(out_valid), 128'(exp_ov));
        if (exp_ov) begin
            got = {takb, mispred, dec_wr, dec_val, tag_o};
            check("result", 128'(got), 128'(q[0].r));
            if (out_ready) begin
                void'(q.pop_front());
                fired++;
            end
        end
        last_acc = in_valid && exp_rdy;
        if (last_acc) q.push_back('{r: model(inst.br.opcode, a, b, pred, tag), cyc: cyc});
        if (flush) q.delete();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string name, input opcode_e op, input logic [63:0] av,
                           input logic [63:0] bv, input logic p, input logic et,
                           input logic edw, input logic [63:0] edv);
        set_op(op, av, bv, p);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        check($sformatf("%s.valid", name), 128'(out_valid), 128'(1'b1));
        check($sformatf("%s.takb", name), 128'(takb), 128'(et));
        check($sformatf("%s.mispred", name), 128'(mispred), 128'(et ^ p));
        check($sformatf("%s.dec_wr", name), 128'(dec_wr), 128'(edw));
        check($sformatf("%s.dec_val", name), 128'(dec_val), 128'(edv));
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, c, base;
        rst_ni = 1'b0;
        in_valid = 1'b0; inst = '{br: '{opcode: NOP}}; a = '0; b = '0; pred = 1'b0; tag = '0;
        flush = 1'b0; out_ready = 1'b1;
        in_valid32 = 1'b0; inst32 = '{br: '{opcode: NOP}}; a32 = '0; b32 = '0; pred32 = 1'b0;
        tag32 = '0; flush32 = 1'b0; out_ready32 = 1'b1;

        // Reset state with an operation offered.
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1;
        #1;
        check("rst.in_ready", 128'(in_ready), 128'(1'b0));
        check("rst.out_valid", 128'(out_valid), 128'(1'b0));
        check("rst.fields", 128'({takb, mispred, dec_wr, dec_val, tag_o}), 128'(0));
        check("rst.in_ready32", 128'(in_ready32), 128'(1'b0));
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        tick();

        // Directed vectors.
        run_one("djne",   DJNE,  64'd5, 64'd0, 1'b1, 1'b1, 1'b1, 64'd4);
        run_one("djnez0", DJNEZ, 64'd0, 64'd9, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_one("djeqz1", DJEQZ, 64'd1, 64'd9, 1'b0, 1'b1, 1'b1, 64'd0);
        run_one("djnez1", DJNEZ, 64'd1, 64'd0, 1'b1, 1'b0, 1'b1, 64'd0);
        run_one("jlt",    JLT,   '1,    64'd1, 1'b0, 1'b1, 1'b0, 64'd0);
        run_one("jltu",   JLTU,  '1,    64'd1, 1'b1, 1'b0, 1'b0, 64'd0);
        run_one("jbs63",  JBS,   64'h8000_0000_0000_0000, 64'h7F, 1'b0, 1'b1, 1'b0, 64'd0);
        run_one("jbc63",  JBC,   64'h8000_0000_0000_0000, 64'hFFFF_FF3F, 1'b0, 1'b0, 1'b0, 64'd0);
        run_one("nop",    NOP,   64'd3, 64'd3, 1'b1, 1'b0, 1'b0, 64'd0);

        // Eight back-to-back ops, consumer stalled on cycles 3..6.
        base = fired;
        sent = 0;
        c = 0;
        set_op(rop(), rval(), rval(), 1'($urandom));
        while ((sent < 8 || q.size() > 0) && c < 40) begin
            c++;
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 8);
            tick();
            if (last_acc) begin
                sent++;
                set_op(rop(), rval(), rval(), 1'($urandom));
            end
        end
        in_valid = 1'b0;
        check("burst.done", 128'(c < 40), 128'(1'b1));
        check("burst.count", 128'(fired - base), 128'(8));

        // Flush with both stages full and a new op offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(JEQ, 64'd1, 64'd1, 1'b0);
        tick();
        set_op(DJNE, 64'd7, 64'd2, 1'b0);
        tick();
        set_op(JNE, 64'd1, 64'd2, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush.out_valid", 128'(out_valid), 128'(1'b0));
        out_ready = 1'b1;
        repeat (4) tick();

        // Randomised stream.
        set_op(rop(), rval(), rval(), 1'($urandom));
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (last_acc) set_op(rop(), rval(), rval(), 1'($urandom));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        check("drain.empty", 128'(q.size()), 128'(0));

        // 32-bit width: decrement wraps at 32 bits.
        in_valid32 = 1'b1; out_ready32 = 1'b0;
        inst32.br.opcode = DJGTU; a32 = 32'd0; b32 = 32'hFFFF_FFFE; pred32 = 1'b0; tag32 = 6'h2A;
        #1;
        check("w32.in_ready", 128'(in_ready32), 128'(1'b1));
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        check("w32.early", 128'(out_valid32), 128'(1'b0));
        @(posedge clk);
        #1;
        check("w32.valid", 128'(out_valid32), 128'(1'b1));
        check("w32.dec_val", 128'(dec_val32), 128'(32'hFFFF_FFFF));
        check("w32.takb", 128'(takb32), 128'(1'b1));
        check("w32.dec_wr", 128'(dec_wr32), 128'(1'b1));
        check("w32.mispred", 128'(mispred32), 128'(1'b1));
        check("w32.tag", 128'(tag_o32), 128'(6'h2A));

        // Reset pulse with both pipes holding work.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_op(DJEQ, 64'd2, 64'd1, 1'b0);
        tick();
        set_op(JGT, 64'd5, 64'd1, 1'b1);
        tick();
        rst_ni = 1'b0;
        #1;
        q.delete();
        check("mrst.out_valid", 128'(out_valid), 128'(1'b0));
        check("mrst.fields", 128'({takb, mispred, dec_wr, dec_val, tag_o}), 128'(0));
        check("mrst.in_ready", 128'(in_ready), 128'(1'b0));
        check("mrst.fields32",
              128'({out_valid32, in_ready32, takb32, mispred32, dec_wr32, dec_val32, tag_o32}), 128'(0));
        tick();
        rst_ni    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        out_ready32 = 1'b1;
        tick();
        check("mrst.in_ready32", 128'(in_ready32), 128'(1'b1));
        check("mrst.out_valid32", 128'(out_valid32), 128'(1'b0));
        repeat (3) tick();
        run_one("post_rst", DJLT, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1, '1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
